int_root_unit: RTL and testbench

- Parametrised iterative integer root extractor; successor to the fixed 8-bit cube-root block.
- Computes floor square root or floor cube root of a WIDTH-bit unsigned operand, selected per request by mode_i, and also returns the remainder.
- Uses the bit-serial restoring recurrence, one result bit per 3-cycle iteration.
- Sits as a slave compute unit behind a start/busy handshake on the shared system clock.

---
 rtl/int_root_unit_if.sv | 35 +++
 rtl/int_root_unit.sv | 138 +++++++++++++
 tb/tb_int_root_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/int_root_unit_if.sv
// Start/busy request bus for int_root_unit.
// The rem_bo signal only exists when INT_ROOT_REM_EN is defined.
interface int_root_unit_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned Y_W = (WIDTH + 1) / 2;

    logic [WIDTH-1:0] a_i;
    logic             mode_i;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic [Y_W-1:0]   y_bo;
`ifdef INT_ROOT_REM_EN
    logic [WIDTH-1:0] rem_bo;

    modport master (
        output a_i, mode_i, start_i,
        input  busy_o, done_o, y_bo, rem_bo
    );
    modport slave (
        input  a_i, mode_i, start_i,
        output busy_o, done_o, y_bo, rem_bo
    );
`else
    modport master (
        output a_i, mode_i, start_i,
        input  busy_o, done_o, y_bo
    );
    modport slave (
        input  a_i, mode_i, start_i,
        output busy_o, done_o, y_bo
    );
`endif
endinterface

// File: rtl/int_root_unit.sv
// Iterative floor square/cube root, one result bit per 3-cycle restoring step.
// Define INT_ROOT_REM_EN to expose the remainder on rem_bo.
module int_root_unit #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk_i,
    input logic            rst_i,
    int_root_unit_if.slave bus
);
    localparam int unsigned Y_W     = (WIDTH + 1) / 2;
    localparam int unsigned B_W     = 2 * WIDTH + 2;
    localparam int unsigned ITER_SQ = Y_W;
    localparam int unsigned ITER_CB = (WIDTH + 2) / 3;
    localparam int unsigned S_W     = $clog2(B_W);
    localparam int unsigned C_W     = $clog2(Y_W + 1);

    localparam logic [S_W-1:0] S_SQ = S_W'(2 * (ITER_SQ - 1));
    localparam logic [S_W-1:0] S_CB = S_W'(3 * (ITER_CB - 1));
    localparam logic [C_W-1:0] C_SQ = C_W'(ITER_SQ);
    localparam logic [C_W-1:0] C_CB = C_W'(ITER_CB);

    typedef enum logic [2:0] {StIdle, StShift, StCalc, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [C_W-1:0]   cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [Y_W-1:0]   y_out_q, y_out_d;
    logic             done_q, done_d;
`ifdef INT_ROOT_REM_EN
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic [B_W-1:0] y_ext, x_ext, f_sq, f_cb;

    // Difference between consecutive powers, computed wide so b never wraps.
    assign y_ext = B_W'(y_q);
    assign x_ext = B_W'(x_q);
    assign f_sq  = (y_ext << 1) + B_W'(1);
    assign f_cb  = B_W'(3) * y_ext * (y_ext + B_W'(1)) + B_W'(1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        y_out_d = y_out_q;
        done_d  = 1'b0;
`ifdef INT_ROOT_REM_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    x_d     = bus.a_i;
                    mode_d  = bus.mode_i;
                    y_d     = '0;
                    s_d     = bus.mode_i ? S_CB : S_SQ;
                    cnt_d   = bus.mode_i ? C_CB : C_SQ;
                    y_out_d = '0;
`ifdef INT_ROOT_REM_EN
                    rem_d   = '0;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                y_d     = y_q << 1;
                state_d = StCalc;
            end
            StCalc: begin
                b_d     = (mode_q ? f_cb : f_sq) << s_q;
                state_d = StCheck;
            end
            StCheck: begin
                if (x_ext >= b_q) begin
                    x_d = x_q - b_q[WIDTH-1:0];
                    y_d = y_q + Y_W'(1);
                end
                s_d     = s_q - (mode_q ? S_W'(3) : S_W'(2));
                cnt_d   = cnt_q - C_W'(1);
                state_d = (cnt_q == C_W'(1)) ? StDone : StShift;
            end
            StDone: begin
                y_out_d = y_q;
`ifdef INT_ROOT_REM_EN
                rem_d   = x_q;
`endif
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            y_out_q <= '0;
            done_q  <= 1'b0;
`ifdef INT_ROOT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            y_out_q <= y_out_d;
            done_q  <= done_d;
`ifdef INT_ROOT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.busy_o = (state_q != StIdle);
    assign bus.done_o = done_q;
    assign bus.y_bo   = y_out_q;
`ifdef INT_ROOT_REM_EN
    assign bus.rem_bo = rem_q;
`endif
endmodule

// File: tb/tb_int_root_unit.sv
// Self-checking bench for int_root_unit at WIDTH=8 and WIDTH=16.
// Remainder checks are active only when INT_ROOT_REM_EN is defined.
module tb_int_root_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    int_root_unit_if #(.WIDTH(8))  bus8 ();
    int_root_unit_if #(.WIDTH(16)) bus16 ();

    int_root_unit #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
    int_root_unit #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

    typedef struct {
        bit          wide;
        logic [15:0] a;
        bit          cube;
        longint      y;
        longint      rem;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pw(input longint v, input bit cube);
        return cube ? v * v * v : v * v;
    endfunction

    // Largest y with y^k <= a, found by plain search.
    function automatic longint ref_root(input longint a, input bit cube);
        longint y = 0;
        while (pw(y + 1, cube) <= a) y++;
        return y;
    endfunction

    function automatic int ref_lat(input int w, input bit cube);
        int iter = cube ? (w + 2) / 3 : (w + 1) / 2;
        return 3 * iter + 1;
    endfunction

    function automatic logic get_done(input bit wide);
        return wide ? bus16.done_o : bus8.done_o;
    endfunction

    function automatic logic get_busy(input bit wide);
        return wide ? bus16.busy_o : bus8.busy_o;
    endfunction

    function automatic longint get_y(input bit wide);
        return wide ? longint'(bus16.y_bo) : longint'(bus8.y_bo);
    endfunction

`ifdef INT_ROOT_REM_EN
    function automatic longint get_rem(input bit wide);
        return wide ? longint'(bus16.rem_bo) : longint'(bus8.rem_bo);
    endfunction
`endif

    task automatic drive(input bit wide, input logic [15:0] a, input bit cube, input logic st);
        if (wide) begin
            bus16.a_i = a; bus16.mode_i = cube; bus16.start_i = st;
        end else begin
            bus8.a_i = a[7:0]; bus8.mode_i = cube; bus8.start_i = st;
        end
    endtask

    // Called at a negedge; waits until done_o is seen, counting posedges in lat.
    // If poke >= 0, a conflicting start is pulsed once mid-run.
    task automatic wait_done(input bit wide, input int poke, input bit cube, inout int lat);
        forever begin
            if (lat == poke) drive(wide, 16'd200, ~cube, 1'b1);
            if (lat == poke + 1) drive(wide, 16'd200, ~cube, 1'b0);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (get_done(wide)) break;
            if (lat > 200) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic run_op(input bit wide, input logic [15:0] a, input bit cube, input int poke,
                          output int lat);
        @(negedge clk);
        drive(wide, a, cube, 1'b1);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        drive(wide, a, cube, 1'b0);
        wait_done(wide, poke, cube, lat);
    endtask

    task automatic check_result(input string tag, input bit wide, input longint a, input bit cube,
                                input int lat);
        longint ey = ref_root(a, cube);
        chk({tag, " y"}, get_y(wide), ey);
`ifdef INT_ROOT_REM_EN
        chk({tag, " rem"}, get_rem(wide), a - pw(ey, cube));
`endif
        chk({tag, " latency"}, lat, ref_lat(wide ? 16 : 8, cube));
    endtask

    vec_t vecs[$];

    initial begin
        int     lat;
        bit     seen;
        longint a;

        vecs.push_back('{0, 16'd27,    1, 3,   0,    10});
        vecs.push_back('{0, 16'd100,   1, 4,   36,   10});
        vecs.push_back('{0, 16'd255,   1, 6,   39,   10});
        vecs.push_back('{0, 16'd0,     1, 0,   0,    10});
        vecs.push_back('{0, 16'd255,   0, 15,  30,   13});
        vecs.push_back('{0, 16'd0,     0, 0,   0,    13});
        vecs.push_back('{0, 16'd1,     0, 1,   0,    13});
        vecs.push_back('{1, 16'd65535, 1, 40,  1535, 19});
        vecs.push_back('{1, 16'd65535, 0, 255, 510,  25});
        vecs.push_back('{1, 16'd0,     1, 0,   0,    19});

        drive(0, 16'd0, 0, 1'b0);
        drive(1, 16'd0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk("reset busy", longint'(get_busy(w[0])), 0);
            chk("reset done", longint'(get_done(w[0])), 0);
            chk("reset y", get_y(w[0]), 0);
`ifdef INT_ROOT_REM_EN
            chk("reset rem", get_rem(w[0]), 0);
`endif
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].wide, vecs[i].a, vecs[i].cube, -1, lat);
            chk($sformatf("vec%0d y", i), get_y(vecs[i].wide), vecs[i].y);
`ifdef INT_ROOT_REM_EN
            chk($sformatf("vec%0d rem", i), get_rem(vecs[i].wide), vecs[i].rem);
`endif
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d busy in done cycle", i), longint'(get_busy(vecs[i].wide)), 0);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse width", i), longint'(get_done(vecs[i].wide)), 0);
        end

        // Random operands against the search model.
        for (int w = 0; w < 2; w++) begin
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 120; n++) begin
                    a = (w == 1) ? longint'($urandom_range(0, 65535))
                                 : longint'($urandom_range(0, 255));
                    run_op(w[0], 16'(a), m[0], -1, lat);
                    check_result($sformatf("rand w%0d m%0d a=%0d", w, m, a), w[0], a, m[0], lat);
                end
            end
        end

        // A start pulsed mid-run must not disturb the latched operand or mode.
        run_op(0, 16'd64, 1, 3, lat);
        check_result("busy start ignored", 0, 64, 1, lat);

        // A start held in the done cycle is accepted immediately.
        run_op(0, 16'd27, 1, -1, lat);
        check_result("b2b first", 0, 27, 1, lat);
        drive(0, 16'd100, 0, 1'b1);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        drive(0, 16'd100, 0, 1'b0);
        chk("b2b busy after accept", longint'(get_busy(0)), 1);
        wait_done(0, -1, 0, lat);
        check_result("b2b second", 0, 100, 0, lat);

        // Reset five cycles into a cube run aborts it without a done pulse.
        @(negedge clk);
        drive(0, 16'd100, 1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 16'd100, 1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", longint'(get_busy(0)), 0);
        chk("abort y", get_y(0), 0);
        chk("abort done", longint'(get_done(0)), 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (get_done(0)) seen = 1'b1;
        end
        chk("abort no done", longint'(seen), 0);
        run_op(0, 16'd8, 1, -1, lat);
        check_result("after abort", 0, 8, 1, lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
